// File: rtl/regfile_write_arbiter_if.sv
// Bundle for the register-file write arbiter: requester handshake plus the
// registered write-port triple. wr_onehot exists only when WR_ARB_ONEHOT_EN is defined.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               hold;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
`ifdef WR_ARB_ONEHOT_EN
  logic [(1<<AW)-1:0] wr_onehot;

  modport master (
    output req_valid, req_addr, req_data, hold,
    input  req_ready, wr_en, wr_addr, wr_data, wr_onehot
  );

  modport slave (
    input  req_valid, req_addr, req_data, hold,
    output req_ready, wr_en, wr_addr, wr_data, wr_onehot
  );
`else
  modport master (
    output req_valid, req_addr, req_data, hold,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, hold,
    output req_ready, wr_en, wr_addr, wr_data
  );
`endif
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ requesters.
// Optional WR_ARB_ONEHOT_EN adds a decoded wr_onehot output from the registered write triple.
module regfile_write_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]     NREQ_W   = (PW+1)'(NREQ);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

  logic [PW-1:0]   ptr;

  logic            gnt_vld_p0;
  logic [PW-1:0]   gnt_idx_p0;
  logic [NREQ-1:0] gnt_p0;
  logic [AW-1:0]   sel_addr_p0;
  logic [DW-1:0]   sel_data_p0;

  logic            wr_en_p1;
  logic [AW-1:0]   wr_addr_p1;
  logic [DW-1:0]   wr_data_p1;

  // Candidate index at distance off from base, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    logic [PW:0] sum;
    sum = {1'b0, base} + (PW+1)'(off);
    if (sum >= NREQ_W) begin
      sum = sum - NREQ_W;
    end
    return sum[PW-1:0];
  endfunction

  // ---- p0: round-robin search starting at ptr ----
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!gnt_vld_p0 && bus.req_valid[rr_idx(ptr, off)]) begin
        gnt_vld_p0 = 1'b1;
        gnt_idx_p0 = rr_idx(ptr, off);
      end
    end
    if (reset || bus.hold) begin
      gnt_vld_p0 = 1'b0;
    end
  end

  always_comb begin
    gnt_p0      = '0;
    sel_addr_p0 = '0;
    sel_data_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vld_p0 && (gnt_idx_p0 == PW'(i))) begin
        gnt_p0[i]   = 1'b1;
        sel_addr_p0 = bus.req_addr[i*AW +: AW];
        sel_data_p0 = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign bus.req_ready = gnt_p0;

  // ---- p1: registered write triple and pointer advance ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_en_p1 <= gnt_vld_p0;
      if (gnt_vld_p0) begin
        wr_addr_p1 <= sel_addr_p0;
        wr_data_p1 <= sel_data_p0;
        ptr        <= (gnt_idx_p0 == LAST_IDX) ? '0 : gnt_idx_p0 + 1'b1;
      end
    end
  end

  assign bus.wr_en   = wr_en_p1;
  assign bus.wr_addr = wr_addr_p1;
  assign bus.wr_data = wr_data_p1;

`ifdef WR_ARB_ONEHOT_EN
  logic [(1<<AW)-1:0] onehot_p1;

  always_comb begin
    onehot_p1 = '0;
    for (int k = 0; k < (1 << AW); k++) begin
      onehot_p1[k] = wr_en_p1 && (wr_addr_p1 == AW'(k));
    end
  end

  assign bus.wr_onehot = onehot_p1;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued at grant
// time and compared against the registered write port one edge later.
module tb_regfile_write_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  wr_t  sb[$];
  wr_t  mon_exp;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  logic [AW-1:0] pay_addr [NREQ];
  logic [DW-1:0] pay_data [NREQ];
`ifdef WR_ARB_ONEHOT_EN
  logic [(1<<AW)-1:0] oh_exp;
`endif

  regfile_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor: one expected entry per granted cycle, consumed one edge later.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      checks++;
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== mon_exp.addr || bus.wr_data !== mon_exp.data) begin
          failures++;
          $display("FAIL wr_port: got en=%b addr=%0d data=%h, want en=1 addr=%0d data=%h",
                   bus.wr_en, bus.wr_addr, bus.wr_data, mon_exp.addr, mon_exp.data);
        end
        last_addr = mon_exp.addr;
        last_data = mon_exp.data;
`ifdef WR_ARB_ONEHOT_EN
        oh_exp = '0;
        oh_exp[mon_exp.addr] = 1'b1;
`endif
      end else begin
        if (bus.wr_en !== 1'b0) begin
          failures++;
          $display("FAIL wr_idle: got en=%b, want en=0", bus.wr_en);
        end
`ifdef WR_ARB_ONEHOT_EN
        oh_exp = '0;
`endif
      end
`ifdef WR_ARB_ONEHOT_EN
      checks++;
      if (bus.wr_onehot !== oh_exp) begin
        failures++;
        $display("FAIL wr_onehot: got %b, want %b", bus.wr_onehot, oh_exp);
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic set_payload(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pay_addr[i] = a;
    pay_data[i] = d;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic drive(input logic [NREQ-1:0] v, input logic h);
    bus.req_valid = v;
    bus.hold      = h;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [NREQ-1:0] exp_seq [3];
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0001;
    reset = 1'b1;
    drive(4'b1111, 1'b0);
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 3'd0 || bus.wr_data !== 32'd0 || bus.req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_init: got en=%b addr=%0d data=%h ready=%b, want 0/0/0/0000",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.req_ready);
    end
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== exp_seq[k]) begin
        failures++;
        $display("FAIL reset_grant%0d: got ready=%b, want %b", k, bus.req_ready, exp_seq[k]);
      end
      sb.push_back('{addr: pay_addr[k], data: pay_data[k]});
      next_cycle();
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 3'd0 || bus.wr_data !== 32'd0 || bus.req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid: got en=%b addr=%0d data=%h ready=%b, want 0/0/0/0000",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.req_ready);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== exp_seq[2]) begin
      failures++;
      $display("FAIL reset_release_grant: got ready=%b, want %b", bus.req_ready, exp_seq[2]);
    end
    sb.push_back('{addr: pay_addr[0], data: pay_data[0]});
    next_cycle();
  endtask

  task automatic test_fairness();
    drive(4'b1000, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL fair_align: got ready=%b, want 1000", bus.req_ready);
    end
    sb.push_back('{addr: pay_addr[3], data: pay_data[3]});
    next_cycle();
    drive(4'b1111, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== (4'b0001 << (k % 4))) begin
        failures++;
        $display("FAIL fair_cycle%0d: got ready=%b, want %b", k, bus.req_ready, 4'b0001 << (k % 4));
      end
      sb.push_back('{addr: pay_addr[k % 4], data: pay_data[k % 4]});
      next_cycle();
    end
  endtask

  task automatic test_pointer_skip();
    logic [NREQ-1:0] vld [5];
    logic [NREQ-1:0] gnt [5];
    int              idx [5];
    vld[0] = 4'b0010; gnt[0] = 4'b0010; idx[0] = 1;
    vld[1] = 4'b0011; gnt[1] = 4'b0001; idx[1] = 0;
    vld[2] = 4'b0011; gnt[2] = 4'b0010; idx[2] = 1;
    vld[3] = 4'b1000; gnt[3] = 4'b1000; idx[3] = 3;
    vld[4] = 4'b1111; gnt[4] = 4'b0001; idx[4] = 0;
    for (int k = 0; k < 5; k++) begin
      drive(vld[k], 1'b0);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== gnt[k]) begin
        failures++;
        $display("FAIL skip_step%0d: got ready=%b, want %b", k, bus.req_ready, gnt[k]);
      end
      sb.push_back('{addr: pay_addr[idx[k]], data: pay_data[idx[k]]});
      next_cycle();
    end
  endtask

  task automatic test_hold();
    drive(4'b0100, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.wr_addr !== last_addr || bus.wr_data !== last_data) begin
        failures++;
        $display("FAIL hold_cycle%0d: got ready=%b addr=%0d data=%h, want 0000 addr=%0d data=%h",
                 k, bus.req_ready, bus.wr_addr, bus.wr_data, last_addr, last_data);
      end
      next_cycle();
    end
    drive(4'b0100, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL hold_release: got ready=%b, want 0100", bus.req_ready);
    end
    sb.push_back('{addr: pay_addr[2], data: pay_data[2]});
    next_cycle();
    drive(4'b1111, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL hold_all%0d: got ready=%b, want 0000", k, bus.req_ready);
      end
      next_cycle();
    end
    drive(4'b1111, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL hold_ptr_kept: got ready=%b, want 1000", bus.req_ready);
    end
    sb.push_back('{addr: pay_addr[3], data: pay_data[3]});
    next_cycle();
  endtask

  task automatic test_idle();
    set_payload(0, 3'd5, 32'hDEAD);
    drive(4'b0001, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL idle_write: got ready=%b, want 0001", bus.req_ready);
    end
    sb.push_back('{addr: 3'd5, data: 32'hDEAD});
    next_cycle();
    drive(4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.wr_addr !== 3'd5 || bus.wr_data !== 32'hDEAD) begin
        failures++;
        $display("FAIL idle_cycle%0d: got ready=%b addr=%0d data=%h, want 0000 addr=5 data=0000dead",
                 k, bus.req_ready, bus.wr_addr, bus.wr_data);
      end
      next_cycle();
    end
  endtask

  task automatic test_onehot();
    set_payload(1, 3'd6, 32'h0000_6666);
    drive(4'b0010, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL onehot_grant: got ready=%b, want 0010", bus.req_ready);
    end
    sb.push_back('{addr: 3'd6, data: 32'h0000_6666});
    next_cycle();
    drive(4'b0000, 1'b0);
    @(negedge clk);
`ifdef WR_ARB_ONEHOT_EN
    checks++;
    if (bus.wr_onehot !== 8'b0100_0000) begin
      failures++;
      $display("FAIL onehot_addr6: got %b, want 01000000", bus.wr_onehot);
    end
`endif
    next_cycle();
  endtask

  task automatic test_same_addr();
    set_payload(2, 3'd4, 32'h0000_0022);
    set_payload(3, 3'd4, 32'h0000_0033);
    drive(4'b1100, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== (4'b0100 << k)) begin
        failures++;
        $display("FAIL same_addr%0d: got ready=%b, want %b", k, bus.req_ready, 4'b0100 << k);
      end
      sb.push_back('{addr: 3'd4, data: pay_data[2 + k]});
      next_cycle();
    end
    drive(4'b0000, 1'b0);
    next_cycle();
    next_cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    last_addr = '0;
    last_data = '0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.hold      = 1'b0;
    reset         = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      set_payload(i, AW'(i), 32'hA0 + 32'(i));
    end
    test_reset();
    test_fairness();
    test_pointer_skip();
    test_hold();
    test_idle();
    test_onehot();
    test_same_addr();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
